bp_fe_queue_buffer: RTL
=======================

BP_FE_QUEUE_BUFFER -- requirements
Module: bp_fe_queue_buffer

Interface
REQ-001 SHALL have parameter els_p, default 8, entry count; power of two, at least 2.
REQ-002 SHALL have parameter width_p, default fe_queue_width_lp, entry width in bits.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_i  input  width_p  FE-produced queue entry.
REQ-006 SHALL have port v_i  input  1  enqueue valid.
REQ-007 SHALL have port ready_o  output  1  space available; enqueue occurs when v_i & ready_o.
REQ-008 SHALL have port data_o  output  width_p  entry at the speculative read pointer.
REQ-009 SHALL have port v_o  output  1  an unread entry is present.
REQ-010 SHALL have port yumi_i  input  1  consumer takes data_o; legal only when v_o=1.
REQ-011 SHALL have port clr_i  input  1  discard every entry.
REQ-012 SHALL have port roll_i  input  1  replay all read-but-uncommitted entries.
REQ-013 SHALL have port deq_i  input  1  commit (free) the oldest read entry.

Function
REQ-014 SHALL keep three pointers of width log2(els_p)+1 that wrap modulo 2*els_p: wptr (write), rptr (speculative read), cptr (commit).
- The extra MSB distinguishes full from empty.
REQ-015 SHALL treat entries from cptr to wptr as occupied, and entries from rptr to wptr as unread.
REQ-016 SHALL drive ready_o = (wptr - cptr) != els_p.
- ready_o SHALL NOT depend on v_i, yumi_i, deq_i, clr_i or roll_i in the same cycle (no pass-through).
REQ-017 SHALL drive v_o = (rptr != wptr) and data_o = mem[rptr low bits], combinationally from registered state.
REQ-018 SHALL write data_i at wptr and increment wptr on enqueue.
- The entry becomes visible on v_o no earlier than the next cycle; there is no enqueue-to-dequeue bypass.
REQ-019 SHALL increment rptr on yumi_i.
REQ-020 SHALL increment cptr on deq_i.
- deq_i is legal only when cptr != rptr.
REQ-021 On roll_i SHALL set rptr to cptr_next, where cptr_next includes a same-cycle deq_i.
- Any same-cycle yumi_i is ignored.
- A same-cycle enqueue still proceeds.
REQ-022 On clr_i SHALL set rptr and cptr to wptr.
- Any same-cycle enqueue, yumi_i, deq_i and roll_i are ignored.
REQ-023 Priority SHALL be clr_i > roll_i > (yumi_i, deq_i).
- yumi_i, deq_i and enqueue are mutually independent and may all occur in one cycle.
REQ-024 At full, a same-cycle deq_i SHALL NOT raise ready_o in that cycle; space becomes available next cycle.
REQ-025 At empty (v_o=0), a same-cycle enqueue SHALL NOT assert v_o until the next cycle.
REQ-026 A pointer increment at value 2*els_p-1 SHALL wrap to 0.
REQ-027 SHALL provide simulation-only assertions that flag:
- yumi_i with v_o=0;
- deq_i with cptr==rptr;
- enqueue with ready_o=0.

Reset
REQ-028 While reset_i=1, SHALL hold wptr=rptr=cptr=0, giving ready_o=1 and v_o=0, independent of clk_i.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately; storage contents are not reset and are don't-care.
REQ-030 In the first edge after reset deasserts, SHALL accept an enqueue.

Structure
REQ-031 The entry type (bp_fe_queue_s) and fe_queue_width_lp SHALL come from the shared FE/BE interface package macros; this block SHALL define no new typedefs.
REQ-032 Pointer width and occupancy arithmetic SHALL be local derived parameters.
REQ-033 Storage SHALL be one bsg_mem_1r1w instance (els_p x width_p, asynchronous read).
- Pointers and control logic SHALL be in the top level.

Verification
REQ-034 Fill: reset, enqueue 8 entries 0x1..0x8 back-to-back (els_p=8) -> ready_o=0 after the 8th; 9th v_i held and not written; v_o=1 with data_o=0x1.
REQ-035 Roll: enqueue A,B,C; yumi 3 times; deq_i once; roll_i -> next cycle v_o=1, data_o=B; two yumi return B,C, then v_o=0.
REQ-036 Clear with simultaneous events: 4 entries, 2 read; assert clr_i together with v_i, yumi_i and deq_i -> next cycle v_o=0, ready_o=1, and the enqueued entry is absent.
REQ-037 Full with deq: full queue, all 8 read; deq_i -> ready_o still 0 that cycle, 1 the next; an enqueue in the following cycle succeeds.
REQ-038 Wrap: stream 40 entries with continuous yumi_i and deq_i one cycle behind, using els_p=4 -> output order equals input order, no v_o bubbles after the first entry, pointers wrap without loss.
REQ-039 Async reset: assert reset_i between edges with 3 entries present -> ready_o=1 and v_o=0 before the next clock edge.

Source files
------------

// File: rtl/bp_fe_queue_buffer_pkg.sv
// Shared FE/BE interface definitions: the FE queue entry and its width.
// The queue buffer sizes its storage from fe_queue_width_lp.
package bp_fe_queue_buffer_pkg;

  localparam int unsigned vaddr_width_lp  = 39;
  localparam int unsigned instr_width_lp  = 32;
  localparam int unsigned bp_meta_width_lp = 8;

  typedef enum logic [1:0] {
    e_fe_fetch       = 2'b00,
    e_fe_exception   = 2'b01,
    e_fe_icache_miss = 2'b10
  } bp_fe_queue_type_e;

  typedef struct packed {
    bp_fe_queue_type_e             msg_type;
    logic [vaddr_width_lp-1:0]     pc;
    logic [instr_width_lp-1:0]     instr;
    logic [bp_meta_width_lp-1:0]   branch_metadata;
  } bp_fe_queue_s;

  localparam int unsigned fe_queue_width_lp = $bits(bp_fe_queue_s);

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One write port, one asynchronous read port register file.
// Contents are never reset; readers must qualify data with their own valid.
module bsg_mem_1r1w #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 8,
  localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  always_ff @(posedge w_clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_queue_buffer.sv
// FE queue with speculative read: entries are read (yumi), then later committed
// (deq) or replayed (roll). clr drops everything, including uncommitted reads.
module bp_fe_queue_buffer
  import bp_fe_queue_buffer_pkg::*;
#(
  parameter int unsigned els_p   = 8,
  parameter int unsigned width_p = fe_queue_width_lp
) (
  input  logic               clk_i,
  input  logic               reset_i,

  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,

  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,

  input  logic               clr_i,
  input  logic               roll_i,
  input  logic               deq_i
);

  localparam int unsigned addr_width_lp = $clog2(els_p);
  // Extra MSB separates full (distance els_p) from empty (distance 0).
  localparam int unsigned ptr_width_lp  = addr_width_lp + 1;
  localparam logic [ptr_width_lp-1:0] els_lp = ptr_width_lp'(els_p);

  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [ptr_width_lp-1:0] cptr_q, cptr_d;
  logic [ptr_width_lp-1:0] cptr_deq;
  logic [ptr_width_lp-1:0] occupancy;
  logic                    enq;
  logic                    mem_w_v;

  // Status comes purely from registered pointers, so nothing passes through.
  assign occupancy = wptr_q - cptr_q;
  assign ready_o   = (occupancy != els_lp);
  assign v_o       = (rptr_q != wptr_q);
  assign enq       = v_i & ready_o;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cptr_d   = cptr_q;
    mem_w_v  = 1'b0;
    cptr_deq = cptr_q + ptr_width_lp'(deq_i);
    if (clr_i) begin
      rptr_d = wptr_q;
      cptr_d = wptr_q;
    end else begin
      mem_w_v = enq;
      wptr_d  = wptr_q + ptr_width_lp'(enq);
      cptr_d  = cptr_deq;
      // Roll replays from the post-commit point and overrides any yumi.
      rptr_d  = roll_i ? cptr_deq : (rptr_q + ptr_width_lp'(yumi_i));
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  bsg_mem_1r1w #(
    .width_p (width_p),
    .els_p   (els_p)
  ) mem (
    .w_clk_i  (clk_i),
    .w_v_i    (mem_w_v),
    .w_addr_i (wptr_q[addr_width_lp-1:0]),
    .w_data_i (data_i),
    .r_addr_i (rptr_q[addr_width_lp-1:0]),
    .r_data_o (data_o)
  );

`ifndef SYNTHESIS
  yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    yumi_i |-> v_o)
    else $error("bp_fe_queue_buffer: yumi_i while v_o=0");

  deq_without_read: assert property (@(posedge clk_i) disable iff (reset_i)
    deq_i |-> (cptr_q != rptr_q))
    else $error("bp_fe_queue_buffer: deq_i with no read-uncommitted entry");

  write_when_full: assert property (@(posedge clk_i) disable iff (reset_i)
    mem_w_v |-> ready_o)
    else $error("bp_fe_queue_buffer: entry written while ready_o=0");
`endif

endmodule
